id_ex_pipe: RTL and testbench

- ID/EX pipeline stage, directly downstream of the decode control unit in the pipelined MIPS datapath.
- Each cycle it registers that unit's control bundle together with the ID-stage operands and register specifiers.
- It also detects load-use hazards against the instruction now in EX, and inserts a bubble on hazard or flush.
- Drives pc_write/ifid_write back to the fetch stage.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/load_use_detect.sv | 23 ++
 rtl/id_ex_pipe.sv | 136 +++++++++++++
 tb/tb_id_ex_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU operation encodings and
// control-bundle bit positions used by the decode and ID/EX stages.
package mips_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned ALU_W  = 3;
    localparam int unsigned CTRL_W = 10;

    // Primary opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;

    // ALU operation encodings
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    // Control bundle bit indices: {Jmp, Brancheq, Branchneq, DataSrc, regDst,
    // regWrite, AluSrc, MemWrite, MemRead, reserved}
    localparam int unsigned CTRL_JMP       = 9;
    localparam int unsigned CTRL_BRANCHEQ  = 8;
    localparam int unsigned CTRL_BRANCHNEQ = 7;
    localparam int unsigned CTRL_DATASRC   = 6;
    localparam int unsigned CTRL_REGDST    = 5;
    localparam int unsigned CTRL_REGWRITE  = 4;
    localparam int unsigned CTRL_ALUSRC    = 3;
    localparam int unsigned CTRL_MEMWRITE  = 2;
    localparam int unsigned CTRL_MEMREAD   = 1;
    localparam int unsigned CTRL_RSVD      = 0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags when the load now in EX writes a register
// the ID instruction reads. Purely combinational; rt is always compared,
// which is conservative for I-type instructions.
module load_use_detect #(
    parameter int unsigned RW = 5
) (
    input  logic          ex_mem_read,
    input  logic          ex_valid,
    input  logic [RW-1:0] ex_rt,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    output logic          luh
);

    logic w_rt_nonzero;
    logic w_match;

    // $zero is never a real dependency
    assign w_rt_nonzero = (ex_rt != '0);
    assign w_match      = (ex_rt == id_rs) | (ex_rt == id_rt);
    assign luh          = ex_mem_read & ex_valid & w_rt_nonzero & w_match;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall and flush bubble insertion.
// Edge priority: hold > flush > load-use hazard > normal load.
// Optional macro ID_EX_PERF_CNT_EN adds saturating stall/flush counters.
module id_ex_pipe
    import mips_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic [ALU_W-1:0]  id_alu_operation,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DW-1:0]     id_rd1,
    input  logic [DW-1:0]     id_rd2,
    input  logic [DW-1:0]     id_imm,
    input  logic [DW-1:0]     id_pc_plus4,
    input  logic [RW-1:0]     id_rs,
    input  logic [RW-1:0]     id_rt,
    input  logic [RW-1:0]     id_rd,
    output logic [ALU_W-1:0]  ex_alu_operation,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DW-1:0]     ex_rd1,
    output logic [DW-1:0]     ex_rd2,
    output logic [DW-1:0]     ex_imm,
    output logic [DW-1:0]     ex_pc_plus4,
    output logic [RW-1:0]     ex_rs,
    output logic [RW-1:0]     ex_rt,
    output logic [RW-1:0]     ex_rd,
    output logic              ex_valid,
`ifdef ID_EX_PERF_CNT_EN
    output logic [15:0]       stall_count,
    output logic [15:0]       flush_count,
`endif
    output logic              pc_write,
    output logic              ifid_write
);

    logic [ALU_W-1:0]  r_alu_operation;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DW-1:0]     r_rd1;
    logic [DW-1:0]     r_rd2;
    logic [DW-1:0]     r_imm;
    logic [DW-1:0]     r_pc_plus4;
    logic [RW-1:0]     r_rs;
    logic [RW-1:0]     r_rt;
    logic [RW-1:0]     r_rd;
    logic              r_valid;

    logic              w_luh;
    logic              w_bubble;

    load_use_detect #(.RW(RW)) u_luh (
        .ex_mem_read (r_ctrl[CTRL_MEMREAD]),
        .ex_valid    (r_valid),
        .ex_rt       (r_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .luh         (w_luh)
    );

    // Flush or hazard turns the ID instruction into a bubble in EX
    assign w_bubble = flush | w_luh;

    // Fetch-side enables: freeze on hold, or on a hazard not overridden by flush
    assign pc_write   = ~hold & (flush | ~w_luh);
    assign ifid_write = ~hold & (flush | ~w_luh);

    // Pipeline register with bubble insertion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_operation <= '0;
            r_ctrl          <= '0;
            r_rd1           <= '0;
            r_rd2           <= '0;
            r_imm           <= '0;
            r_pc_plus4      <= '0;
            r_rs            <= '0;
            r_rt            <= '0;
            r_rd            <= '0;
            r_valid         <= 1'b0;
        end else if (!hold) begin
            r_rd1      <= id_rd1;
            r_rd2      <= id_rd2;
            r_imm      <= id_imm;
            r_pc_plus4 <= id_pc_plus4;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_rd       <= id_rd;
            if (w_bubble) begin
                r_alu_operation <= ALU_AND;
                r_ctrl          <= '0;
                r_valid         <= 1'b0;
            end else begin
                r_alu_operation <= id_alu_operation;
                r_ctrl          <= id_ctrl;
                r_valid         <= 1'b1;
            end
        end
    end

    assign ex_alu_operation = r_alu_operation;
    assign ex_ctrl          = r_ctrl;
    assign ex_rd1           = r_rd1;
    assign ex_rd2           = r_rd2;
    assign ex_imm           = r_imm;
    assign ex_pc_plus4      = r_pc_plus4;
    assign ex_rs            = r_rs;
    assign ex_rt            = r_rt;
    assign ex_rd            = r_rd;
    assign ex_valid         = r_valid;

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    // Saturating counts of load-use stalls taken and flush bubbles inserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (!hold) begin
            if (w_luh && !flush && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
            if (flush && (r_flush_count != 16'hFFFF))
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios followed by random
// traffic, all compared against a behavioural model of the EX-stage contents.
module tb_id_ex_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hold, flush;
    logic [2:0]    id_alu_operation;
    logic [9:0]    id_ctrl;
    logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc_plus4;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [2:0]    ex_alu_operation;
    logic [9:0]    ex_ctrl;
    logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc_plus4;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd;
    logic          ex_valid, pc_write, ifid_write;
`ifdef ID_EX_PERF_CNT_EN
    logic [15:0]   stall_count, flush_count;
`endif

    id_ex_pipe #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
        .id_alu_operation(id_alu_operation), .id_ctrl(id_ctrl),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc_plus4(id_pc_plus4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_alu_operation(ex_alu_operation), .ex_ctrl(ex_ctrl),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc_plus4(ex_pc_plus4),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_valid(ex_valid),
`ifdef ID_EX_PERF_CNT_EN
        .stall_count(stall_count), .flush_count(flush_count),
`endif
        .pc_write(pc_write), .ifid_write(ifid_write)
    );

    always #5 clk = ~clk;

    // Control bundle bit masks as seen by the outside world
    localparam logic [9:0] C_JMP  = 10'b10_0000_0000;
    localparam logic [9:0] C_BEQ  = 10'b01_0000_0000;
    localparam logic [9:0] C_RDST = 10'b00_0010_0000;
    localparam logic [9:0] C_RWR  = 10'b00_0001_0000;
    localparam logic [9:0] C_ASRC = 10'b00_0000_1000;
    localparam logic [9:0] C_MRD  = 10'b00_0000_0010;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected EX-stage instruction, modelled as one record
    typedef struct {
        logic [2:0]    alu;
        logic [9:0]    ctrl;
        logic [DW-1:0] rd1, rd2, imm, pc4;
        logic [RW-1:0] rs, rt, rd;
        logic          valid;
    } ex_rec_t;

    ex_rec_t m;
    int      m_stalls;
    int      m_flushes;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic bit model_luh();
        // A real load in EX whose destination is a nonzero source of ID
        return (m.ctrl & C_MRD) != 0 && m.valid && m.rt != 0 &&
               (m.rt == id_rs || m.rt == id_rt);
    endfunction

    task automatic model_reset();
        m = '{alu: 3'd0, ctrl: 10'd0, rd1: '0, rd2: '0, imm: '0, pc4: '0,
              rs: '0, rt: '0, rd: '0, valid: 1'b0};
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        bit hz;
        if (hold) return;
        hz = model_luh();
        if (flush && m_flushes < 65535) m_flushes++;
        if (hz && !flush && m_stalls < 65535) m_stalls++;
        m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm; m.pc4 = id_pc_plus4;
        m.rs  = id_rs;  m.rt  = id_rt;  m.rd  = id_rd;
        if (flush || hz) begin
            m.alu = 3'd0; m.ctrl = 10'd0; m.valid = 1'b0;
        end else begin
            m.alu = id_alu_operation; m.ctrl = id_ctrl; m.valid = 1'b1;
        end
    endtask

    task automatic check_regs();
        check("ex_alu_operation", 64'(ex_alu_operation), 64'(m.alu));
        check("ex_ctrl",          64'(ex_ctrl),          64'(m.ctrl));
        check("ex_rd1",           64'(ex_rd1),           64'(m.rd1));
        check("ex_rd2",           64'(ex_rd2),           64'(m.rd2));
        check("ex_imm",           64'(ex_imm),           64'(m.imm));
        check("ex_pc_plus4",      64'(ex_pc_plus4),      64'(m.pc4));
        check("ex_rs",            64'(ex_rs),            64'(m.rs));
        check("ex_rt",            64'(ex_rt),            64'(m.rt));
        check("ex_rd",            64'(ex_rd),            64'(m.rd));
        check("ex_valid",         64'(ex_valid),         64'(m.valid));
`ifdef ID_EX_PERF_CNT_EN
        check("stall_count",      64'(stall_count),      64'(m_stalls));
        check("flush_count",      64'(flush_count),      64'(m_flushes));
`endif
    endtask

    // Fetch enables from the model: stall only for an unflushed hazard
    task automatic check_enables();
        logic exp_we;
        exp_we = !hold && (flush || !model_luh());
        check("pc_write",   64'(pc_write),   64'(exp_we));
        check("ifid_write", 64'(ifid_write), 64'(exp_we));
    endtask

    task automatic drive(input logic [2:0] alu, input logic [9:0] ctrl,
                         input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                         input logic [RW-1:0] rd);
        id_alu_operation = alu; id_ctrl = ctrl;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom; id_pc_plus4 = $urandom;
    endtask

    // Settle combinational outputs, check them, then take one clock edge
    task automatic tick();
        #1 check_enables();
        @(posedge clk);
        model_edge();
        #1 check_regs();
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
        drive(3'd0, 10'd0, 5'd0, 5'd0, 5'd0);
        model_reset();
        #12;
        check_regs();
        check_enables();
        @(negedge clk);
        rst_n = 1'b1;

        // Normal beq
        drive(3'b110, C_BEQ, 5'd4, 5'd5, 5'd0);
        tick();
        check("beq_alu", 64'(ex_alu_operation), 64'(3'b110));
        check("beq_brancheq", 64'(ex_ctrl[8]), 64'd1);
        check("beq_rs", 64'(ex_rs), 64'd4);
        check("beq_valid", 64'(ex_valid), 64'd1);

        // Load-use: lw $8 then add using $8
        drive(3'b010, C_MRD | C_RWR | C_ASRC, 5'd2, 5'd8, 5'd0);
        tick();
        drive(3'b010, C_RDST | C_RWR, 5'd8, 5'd9, 5'd10);
        #1;
        check("luh_pc_write", 64'(pc_write), 64'd0);
        check("luh_ifid_write", 64'(ifid_write), 64'd0);
        tick();
        check("luh_bubble_valid", 64'(ex_valid), 64'd0);
        check("luh_bubble_regwrite", 64'(ex_ctrl[4]), 64'd0);
        #1 check("luh_release_pc_write", 64'(pc_write), 64'd1);
        tick();
        check("luh_add_rs", 64'(ex_rs), 64'd8);
        check("luh_add_valid", 64'(ex_valid), 64'd1);

        // $zero immunity
        drive(3'b010, C_MRD | C_RWR | C_ASRC, 5'd3, 5'd0, 5'd0);
        tick();
        drive(3'b010, C_RDST | C_RWR, 5'd0, 5'd7, 5'd6);
        #1 check("zero_pc_write", 64'(pc_write), 64'd1);
        tick();

        // Flush overrides hazard
        drive(3'b010, C_MRD | C_RWR | C_ASRC, 5'd1, 5'd8, 5'd0);
        tick();
        drive(3'b010, C_RDST | C_RWR, 5'd8, 5'd8, 5'd4);
        flush = 1'b1;
        #1 check("flush_pc_write", 64'(pc_write), 64'd1);
        check("flush_ifid_write", 64'(ifid_write), 64'd1);
        tick();
        flush = 1'b0;
        check("flush_bubble_valid", 64'(ex_valid), 64'd0);

        // Hold for 3 cycles during a load
        drive(3'b010, C_MRD | C_RWR | C_ASRC, 5'd5, 5'd11, 5'd0);
        tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(3'b001, C_JMP, 5'd11, 5'd12, 5'd13);
            tick();
            check("hold_rt", 64'(ex_rt), 64'd11);
            #1 check("hold_pc_write", 64'(pc_write), 64'd0);
        end
        hold = 1'b0;
        drive(3'b111, C_RDST | C_RWR, 5'd14, 5'd15, 5'd16);
        tick();
        check("hold_release_valid", 64'(ex_valid), 64'd1);

        // Reset pulse between edges
        drive(3'b010, C_RDST | C_RWR, 5'd1, 5'd2, 5'd3);
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check("rst_pc_write", 64'(pc_write), 64'd1);
        rst_n = 1'b1;

        // Random traffic with a narrow register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [9:0] c;
            c = 10'($urandom) & 10'h3FE;
            if ($urandom_range(0, 1) == 0) c = c | C_MRD;
            drive(3'($urandom), c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom));
            hold  = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 6) == 0);
            tick();
        end
        hold = 1'b0; flush = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
